// File: rtl/parallel2serial_tx.sv
// Word-to-bitstream serializer: one-word holding register in front of a shifter,
// so the next word can be queued while the current one shifts out.
module parallel2serial_tx #(
  parameter int DATA_W     = 8,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din_parallel,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              dout_serial,
  output logic              dout_valid,
  output logic              dout_last,
  output logic              busy
);

  localparam int            CW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(DATA_W - 1);
  localparam logic [3:0]    GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] hold, shreg, shreg_nxt;
  logic              hold_full, hold_full_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [3:0]        gap_cnt, gap_cnt_nxt;
  logic              load, accept;
  logic              ser_nxt, vld_nxt, last_nxt, busy_nxt;

  assign din_ready = !hold_full;
  assign accept    = din_valid && !hold_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    cnt_nxt     = cnt;
    gap_cnt_nxt = gap_cnt;
    unique case (state)
      IDLE: begin
        if (hold_full) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != BIT_LAST) begin
          cnt_nxt = cnt + 1'b1;
        end else if (GAP_CYCLES > 0) begin
          state_nxt   = GAP;
          gap_cnt_nxt = '0;
        end else if (hold_full) begin
          // reload on the last-bit edge so the next word follows with no bubble
          load = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt != GAP_LAST) begin
          gap_cnt_nxt = gap_cnt + 1'b1;
        end else if (hold_full) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (load) cnt_nxt = '0;
  end

  // shifter keeps the bit on air at its output end (MSB or LSB)
  always_comb begin
    if (load)
      shreg_nxt = hold;
    else if (state == SHIFT)
      shreg_nxt = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
    else
      shreg_nxt = shreg;
  end

  always_comb begin
    vld_nxt       = load || ((state == SHIFT) && (cnt != BIT_LAST));
    last_nxt      = vld_nxt && (cnt_nxt == BIT_LAST);
    ser_nxt       = vld_nxt && ((MSB_FIRST != 0) ? shreg_nxt[DATA_W-1] : shreg_nxt[0]);
    hold_full_nxt = load ? 1'b0 : (accept ? 1'b1 : hold_full);
    busy_nxt      = hold_full_nxt || (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold        <= '0;
      hold_full   <= 1'b0;
      shreg       <= '0;
      cnt         <= '0;
      gap_cnt     <= '0;
      dout_serial <= 1'b0;
      dout_valid  <= 1'b0;
      dout_last   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (accept) hold <= din_parallel;
      hold_full   <= hold_full_nxt;
      shreg       <= shreg_nxt;
      cnt         <= cnt_nxt;
      gap_cnt     <= gap_cnt_nxt;
      dout_serial <= ser_nxt;
      dout_valid  <= vld_nxt;
      dout_last   <= last_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_parallel2serial_tx.sv
// Three serializers (MSB/no gap, LSB/no gap, MSB/gap 2) checked every cycle against a
// timeline model, plus hand-computed stream, latency and reset expectations.
module tb_parallel2serial_tx;
  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din [N];
  logic       vld [N];
  logic       rdy [N], ser [N], ov [N], ol [N], bsy [N];

  int checks = 0, errors = 0, cyc = 0, last_acc = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    parallel2serial_tx #(
      .DATA_W(8), .MSB_FIRST(g == 1 ? 0 : 1), .GAP_CYCLES(g == 2 ? 2 : 0)
    ) u_dut (
      .clk(clk), .rst(rst),
      .din_parallel(din[g]), .din_valid(vld[g]), .din_ready(rdy[g]),
      .dout_serial(ser[g]), .dout_valid(ov[g]), .dout_last(ol[g]), .busy(bsy[g])
    );
  end

  function automatic int gapof(int d);
    return (d == 2) ? 2 : 0;
  endfunction

  function automatic bit msbf(int d);
    return d != 1;
  endfunction

  // Model: each word occupies a timeline of 8 bit slots then gapof() idle slots.
  // pos = slot currently on the output, -1 = nothing scheduled.
  int         pos    [N] = '{-1, -1, -1};
  logic       hfull  [N] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] hold_m [N] = '{8'h0, 8'h0, 8'h0};
  logic [7:0] cur    [N] = '{8'h0, 8'h0, 8'h0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < N; d++) begin
        pos[d]   = -1;
        hfull[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < N; d++) begin
        logic take;
        take = vld[d] && !hfull[d];
        if (pos[d] >= 0) begin
          pos[d]++;
          if (pos[d] == 8 + gapof(d)) pos[d] = -1;
        end
        if (pos[d] < 0 && hfull[d]) begin
          cur[d]   = hold_m[d];
          pos[d]   = 0;
          hfull[d] = 1'b0;
        end
        if (take) begin
          hold_m[d] = din[d];
          hfull[d]  = 1'b1;
        end
      end
    end
  end

  // capture of the emitted stream
  logic [31:0] acc  [N] = '{32'h0, 32'h0, 32'h0};
  int          nv   [N] = '{0, 0, 0};
  int          nl   [N] = '{0, 0, 0};
  int          lastc[N] = '{0, 0, 0};
  int          vcyc [N][256];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic [4:0] a, e;
    int p;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int d = 0; d < N; d++) begin
      p    = pos[d];
      e[4] = !hfull[d];
      e[3] = hfull[d] || (p >= 0);
      e[2] = (p >= 0) && (p < 8);
      e[1] = (p == 7);
      e[0] = e[2] ? cur[d][msbf(d) ? 7 - p : p] : 1'b0;
      a    = {rdy[d], bsy[d], ov[d], ol[d], ser[d]};
      chk($sformatf("cycle%0d_u%0d {ready,busy,valid,last,serial}", cyc, d), int'(a), int'(e));
      if (ov[d] === 1'b1) begin
        acc[d] = {acc[d][30:0], ser[d]};
        if (nv[d] < 256) vcyc[d][nv[d]] = cyc;
        nv[d]++;
        if (ol[d] === 1'b1) begin
          nl[d]++;
          lastc[d] = cyc;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // present a word on DUT d until it is taken; keep=1 leaves din_valid asserted
  task automatic send(input int d, input logic [7:0] w, input bit keep);
    int n;
    n = 0;
    din[d] = w;
    vld[d] = 1'b1;
    while (rdy[d] !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk($sformatf("accept_timeout_u%0d", d), n, 0);
    tick();
    last_acc = cyc;
    if (!keep) vld[d] = 1'b0;
  endtask

  initial begin
    int b, lb;
    for (int d = 0; d < N; d++) begin
      din[d] = 8'h00;
      vld[d] = 1'b0;
    end

    // reset state
    tick();
    chk("reset_outputs {valid,last,serial,busy}", int'({ov[0], ol[0], ser[0], bsy[0]}), 0);
    rst = 1'b0;
    tick();
    chk("ready_after_reset", int'(rdy[0]), 1);

    // single word, MSB first
    b = nv[0]; lb = nl[0];
    send(0, 8'hA5, 1'b0);
    idle(12);
    chk("a5_word", int'(acc[0][7:0]), 8'hA5);
    chk("a5_bitcount", nv[0] - b, 8);
    chk("a5_first_latency", vcyc[0][b] - last_acc, 1);
    chk("a5_last_latency", lastc[0] - last_acc, 8);
    chk("a5_last_count", nl[0] - lb, 1);

    // back-to-back, no gap
    b = nv[0]; lb = nl[0];
    send(0, 8'h3C, 1'b1);
    send(0, 8'hC3, 1'b0);
    idle(20);
    chk("b2b_stream", int'(acc[0][15:0]), 16'h3CC3);
    chk("b2b_contiguous", vcyc[0][b+15] - vcyc[0][b], 15);
    chk("b2b_last_count", nl[0] - lb, 2);
    chk("b2b_busy_done", int'(bsy[0]), 0);

    // same pair with two idle cycles between words
    b = nv[2];
    send(2, 8'h3C, 1'b1);
    send(2, 8'hC3, 1'b0);
    idle(24);
    chk("gap_stream", int'(acc[2][15:0]), 16'h3CC3);
    chk("gap_word1_span", vcyc[2][b+7] - vcyc[2][b], 7);
    chk("gap_idle_between", vcyc[2][b+8] - vcyc[2][b+7], 3);
    chk("gap_word2_span", vcyc[2][b+15] - vcyc[2][b+8], 7);

    // backpressure with din_valid held high
    b = nv[0];
    send(0, 8'h11, 1'b1);
    chk("bp_ready_low_when_full", int'(rdy[0]), 0);
    send(0, 8'h22, 1'b1);
    send(0, 8'h33, 1'b0);
    idle(30);
    chk("bp_stream", int'(acc[0][23:0]), 24'h112233);
    chk("bp_bitcount", nv[0] - b, 24);

    // LSB first
    b = nv[1]; lb = nl[1];
    send(1, 8'h01, 1'b0);
    idle(12);
    chk("lsb_stream_order", int'(acc[1][7:0]), 8'h80);
    chk("lsb_last_on_final", lastc[1] - vcyc[1][b+7], 0);
    chk("lsb_last_count", nl[1] - lb, 1);

    // reset mid-word
    b = nv[0];
    send(0, 8'hFF, 1'b0);
    idle(3);
    chk("midword_three_bits", nv[0] - b, 3);
    chk("midword_valid_before_rst", int'(ov[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs {valid,last,serial,busy}", int'({ov[0], ol[0], ser[0], bsy[0]}), 0);
    tick();
    rst = 1'b0;
    b = nv[0];
    idle(8);
    chk("no_valid_after_reset", nv[0] - b, 0);
    send(0, 8'h5A, 1'b0);
    idle(12);
    chk("post_reset_word", int'(acc[0][7:0]), 8'h5A);
    chk("post_reset_bitcount", nv[0] - b, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
